// File: rtl/regfile_op_sequencer.sv
// ---------------------------------------------------------------------------
// regfile_op_sequencer
//
// Purpose:
//   Command-driven controller for a 16 x 20-bit register file.
//   It accepts one operation per valid/ready handshake, drives the register
//   file read addresses, captures both operands, computes a result and issues
//   a single write-back. A CLEAR command zeroes all registers, one per cycle.
//
//   Flow per command:
//     arithmetic / LOADI / MOV : IDLE -> READ -> EXEC -> WRITE -> IDLE
//     NOP                      : IDLE -> WRITE (write suppressed) -> IDLE
//     CLEAR                    : IDLE -> CLR (16 cycles) -> IDLE
//
// Configuration:
//   RFSEQ_SATURATE_EN - when defined, ADD saturates to all-ones on overflow
//                       and SUB clamps to zero on borrow. flag_carry still
//                       reports the raw overflow/borrow. When undefined,
//                       results wrap modulo 2^DW.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   cmd_valid    in   command present
//   cmd_ready    out  sequencer can accept a command
//   cmd_op       in   0 NOP, 1 LOADI, 2 MOV, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 CLEAR
//   cmd_dst      in   destination register
//   cmd_srcA     in   operand A register
//   cmd_srcB     in   operand B register
//   cmd_imm      in   immediate for LOADI
//   rf_rdAddrA   out  register file read address A
//   rf_rdAddrB   out  register file read address B
//   rf_rdDataA   in   register file read data A (combinational)
//   rf_rdDataB   in   register file read data B (combinational)
//   rf_write     out  register file write enable
//   rf_wrAddr    out  register file write address
//   rf_wrData    out  register file write data
//   done         out  one-cycle pulse when an operation retires
//   flag_zero    out  last write-back result was zero
//   flag_carry   out  carry/borrow of the last ADD/SUB
// ---------------------------------------------------------------------------
module regfile_op_sequencer #(
    parameter int DW = 20,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_dst,
    input  logic [AW-1:0] cmd_srcA,
    input  logic [AW-1:0] cmd_srcB,
    input  logic [DW-1:0] cmd_imm,
    output logic [AW-1:0] rf_rdAddrA,
    output logic [AW-1:0] rf_rdAddrB,
    input  logic [DW-1:0] rf_rdDataA,
    input  logic [DW-1:0] rf_rdDataB,
    output logic          rf_write,
    output logic [AW-1:0] rf_wrAddr,
    output logic [DW-1:0] rf_wrData,
    output logic          done,
    output logic          flag_zero,
    output logic          flag_carry
);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LOADI = 3'd1;
    localparam logic [2:0] OP_MOV   = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_AND   = 3'd5;
    localparam logic [2:0] OP_OR    = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WRITE,
        S_CLR
    } state_t;

    state_t        state;
    logic [2:0]    op_q;
    logic [AW-1:0] dst_q;
    logic [AW-1:0] clr_cnt;
    logic [AW-1:0] clr_next;

    // Datapath registers carry no reset: they are always loaded before use.
    logic [DW-1:0] imm_q;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;

    logic [DW:0]   sum;
    logic [DW:0]   diff;
    logic [DW-1:0] exec_result;
    logic          exec_carry;
    logic          accept;

`ifdef RFSEQ_SATURATE_EN
    // Clamp an unsigned DW+1-bit sum to the largest representable value.
    function automatic logic [DW-1:0] sat_add(input logic [DW:0] s);
        return s[DW] ? {DW{1'b1}} : s[DW-1:0];
    endfunction

    // Clamp an unsigned DW+1-bit difference to zero when it borrowed.
    function automatic logic [DW-1:0] sat_sub(input logic [DW:0] d);
        return d[DW] ? {DW{1'b0}} : d[DW-1:0];
    endfunction
`endif

    assign accept   = (state == S_IDLE) && cmd_valid && cmd_ready;
    assign clr_next = clr_cnt + 1'b1;

    // Zero-extended operands: bit DW of the sum is the carry, bit DW of the
    // difference is the borrow (set exactly when A < B).
    always_comb begin
        sum         = {1'b0, op_a} + {1'b0, op_b};
        diff        = {1'b0, op_a} - {1'b0, op_b};
        exec_result = '0;
        exec_carry  = 1'b0;
        case (op_q)
            OP_LOADI: exec_result = imm_q;
            OP_MOV:   exec_result = op_a;
            OP_ADD: begin
`ifdef RFSEQ_SATURATE_EN
                exec_result = sat_add(sum);
`else
                exec_result = sum[DW-1:0];
`endif
                exec_carry  = sum[DW];
            end
            OP_SUB: begin
`ifdef RFSEQ_SATURATE_EN
                exec_result = sat_sub(diff);
`else
                exec_result = diff[DW-1:0];
`endif
                exec_carry  = diff[DW];
            end
            OP_AND:   exec_result = op_a & op_b;
            OP_OR:    exec_result = op_a | op_b;
            default:  exec_result = '0;
        endcase
    end

    // ---- operand capture: immediate at the handshake, register data in READ
    always_ff @(posedge clk) begin
        if (accept) begin
            imm_q <= cmd_imm;
        end
        if (state == S_READ) begin
            op_a <= rf_rdDataA;
            op_b <= rf_rdDataB;
        end
    end

    // ---- control FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cmd_ready  <= 1'b1;
            op_q       <= OP_NOP;
            dst_q      <= '0;
            clr_cnt    <= '0;
            rf_rdAddrA <= '0;
            rf_rdAddrB <= '0;
            rf_write   <= 1'b0;
            rf_wrAddr  <= '0;
            rf_wrData  <= '0;
            done       <= 1'b0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
        end else begin
            // Write enable and done are single-cycle pulses unless re-armed.
            rf_write <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q       <= cmd_op;
                        dst_q      <= cmd_dst;
                        rf_rdAddrA <= cmd_srcA;
                        rf_rdAddrB <= cmd_srcB;
                        cmd_ready  <= 1'b0;
                        case (cmd_op)
                            OP_NOP: begin
                                state     <= S_WRITE;
                                rf_wrAddr <= cmd_dst;
                                done      <= 1'b1;
                            end
                            OP_CLEAR: begin
                                state     <= S_CLR;
                                clr_cnt   <= '0;
                                rf_write  <= 1'b1;
                                rf_wrAddr <= '0;
                                rf_wrData <= '0;
                                flag_zero <= 1'b1;
                            end
                            default: state <= S_READ;
                        endcase
                    end
                end
                S_READ: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    // The result lands in rf_wrData together with the write
                    // strobe so that WRITE presents everything in one cycle.
                    state     <= S_WRITE;
                    rf_write  <= 1'b1;
                    rf_wrAddr <= dst_q;
                    rf_wrData <= exec_result;
                    done      <= 1'b1;
                    flag_zero <= (exec_result == '0);
                    if (op_q == OP_ADD || op_q == OP_SUB) begin
                        flag_carry <= exec_carry;
                    end
                end
                S_WRITE: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                end
                S_CLR: begin
                    // clr_cnt is the address being written this cycle; it
                    // wraps back to zero after the last register.
                    clr_cnt <= clr_next;
                    if (clr_cnt == {AW{1'b1}}) begin
                        state     <= S_IDLE;
                        cmd_ready <= 1'b1;
                    end else begin
                        rf_write  <= 1'b1;
                        rf_wrAddr <= clr_next;
                        rf_wrData <= '0;
                        done      <= (clr_next == {AW{1'b1}});
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
